// File: rtl/opl3_i2s_tx.sv
// OPL3 I2S transmitter: single holding register rate adapter and BCLK/LRCLK generator.
// Optional OPL3_I2S_STATS_EN adds saturating underrun_cnt/overrun_cnt outputs.
module opl3_i2s_tx #(
   parameter int DAC_OUTPUT_WIDTH = 16,
   parameter int SLOT_WIDTH       = 32,
   parameter int BCLK_HALF_DIV    = 8
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               sample_valid,
   input  logic signed [DAC_OUTPUT_WIDTH-1:0] sample_l,
   input  logic signed [DAC_OUTPUT_WIDTH-1:0] sample_r,
   output logic                               i2s_bclk,
   output logic                               i2s_lrclk,
   output logic                               i2s_sdata,
   output logic                               frame_start,
   output logic                               underrun,
   output logic                               overrun
`ifdef OPL3_I2S_STATS_EN
   ,
   output logic [15:0]                        underrun_cnt,
   output logic [15:0]                        overrun_cnt
`endif
);

   localparam int FRAME_BITS = 2 * SLOT_WIDTH;
   localparam int BW = $clog2(FRAME_BITS);
   localparam int DW = (BCLK_HALF_DIV > 1) ? $clog2(BCLK_HALF_DIV) : 1;
   localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_BITS - 1);
   localparam logic [BW-1:0] SLOT_W   = BW'(SLOT_WIDTH);
   localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_HALF_DIV - 1);

   logic [DW-1:0] div_cnt;
   logic [BW-1:0] bit_cnt;
   logic [BW-1:0] bit_nxt;
   logic [BW-1:0] slot_k;
   logic signed [DAC_OUTPUT_WIDTH-1:0] tx_l;
   logic signed [DAC_OUTPUT_WIDTH-1:0] tx_r;
   logic signed [DAC_OUTPUT_WIDTH-1:0] hold_l;
   logic signed [DAC_OUTPUT_WIDTH-1:0] hold_r;
   logic signed [DAC_OUTPUT_WIDTH-1:0] tx_sel;
   logic hold_full;
   logic div_wrap;
   logic fall;
   logic frame_evt;
   logic right_nxt;
   logic sdata_nxt;
   logic load_tx;
   logic underrun_nxt;
   logic overrun_nxt;

   assign div_wrap  = (div_cnt == DIV_LAST);
   assign fall      = div_wrap && i2s_bclk;
   assign frame_evt = fall && (bit_cnt == BIT_LAST);
   assign bit_nxt   = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
   assign right_nxt = (bit_nxt >= SLOT_W);
   assign slot_k    = right_nxt ? bit_nxt - SLOT_W : bit_nxt;
   assign tx_sel    = right_nxt ? tx_r : tx_l;

   // Slot bit k carries sample bit W-k; bit 0 is the I2S one-BCLK delay
   always_comb begin
      sdata_nxt = 1'b0;
      for (int i = 1; i <= DAC_OUTPUT_WIDTH; i++) begin
         if (slot_k == BW'(i)) sdata_nxt = tx_sel[DAC_OUTPUT_WIDTH-i];
      end
   end

   assign load_tx      = frame_evt && hold_full;
   assign underrun_nxt = frame_evt && !hold_full;
   assign overrun_nxt  = sample_valid && hold_full && !frame_evt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_cnt     <= '0;
         bit_cnt     <= BIT_LAST;
         i2s_bclk    <= 1'b0;
         i2s_lrclk   <= 1'b0;
         i2s_sdata   <= 1'b0;
         frame_start <= 1'b0;
         underrun    <= 1'b0;
         overrun     <= 1'b0;
         tx_l        <= '0;
         tx_r        <= '0;
         hold_l      <= '0;
         hold_r      <= '0;
         hold_full   <= 1'b0;
      end else begin
         frame_start <= frame_evt;
         underrun    <= underrun_nxt;
         overrun     <= overrun_nxt;
         if (div_wrap) begin
            div_cnt  <= '0;
            i2s_bclk <= ~i2s_bclk;
         end else begin
            div_cnt  <= div_cnt + 1'b1;
         end
         if (fall) begin
            bit_cnt   <= bit_nxt;
            i2s_lrclk <= right_nxt;
            i2s_sdata <= sdata_nxt;
         end
         if (load_tx) begin
            tx_l <= hold_l;
            tx_r <= hold_r;
         end
         // A write on the frame-start clk lands after the load consumed the old value
         if (sample_valid) begin
            hold_l    <= sample_l;
            hold_r    <= sample_r;
            hold_full <= 1'b1;
         end else if (frame_evt) begin
            hold_full <= 1'b0;
         end
      end
   end

`ifdef OPL3_I2S_STATS_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         underrun_cnt <= '0;
         overrun_cnt  <= '0;
      end else begin
         if (underrun_nxt && (underrun_cnt != 16'hFFFF))
            underrun_cnt <= underrun_cnt + 16'd1;
         if (overrun_nxt && (overrun_cnt != 16'hFFFF))
            overrun_cnt <= overrun_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_opl3_i2s_tx.sv
// Directed testbench for opl3_i2s_tx: timing after reset, serial bit patterns,
// underrun repeat, overrun, frame-start collision and mid-frame reset.
module tb_opl3_i2s_tx;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        sample_valid = 1'b0;
   logic [15:0] sample_l = '0;
   logic [15:0] sample_r = '0;
   logic        i2s_bclk;
   logic        i2s_lrclk;
   logic        i2s_sdata;
   logic        frame_start;
   logic        underrun;
   logic        overrun;
`ifdef OPL3_I2S_STATS_EN
   logic [15:0] underrun_cnt;
   logic [15:0] overrun_cnt;
`endif

   int tests = 0;
   int fails = 0;
   int cyc = 0;

   localparam logic [63:0] PAT_D  = 64'h0000_FFFC_0001_0002;
   localparam logic [63:0] PAT_LR = 64'hFFFF_FFFF_0000_0000;

   always #5 clk = ~clk;

   opl3_i2s_tx dut (
      .clk          (clk),
      .reset        (reset),
      .sample_valid (sample_valid),
      .sample_l     (sample_l),
      .sample_r     (sample_r),
      .i2s_bclk     (i2s_bclk),
      .i2s_lrclk    (i2s_lrclk),
      .i2s_sdata    (i2s_sdata),
      .frame_start  (frame_start),
      .underrun     (underrun),
      .overrun      (overrun)
`ifdef OPL3_I2S_STATS_EN
      ,
      .underrun_cnt (underrun_cnt),
      .overrun_cnt  (overrun_cnt)
`endif
   );

   initial begin
      #3_000_000;
      $display("FAIL watchdog expired at cyc %0d", cyc);
      $fatal(1);
   end

   function automatic logic [63:0] exp_frame(input logic [15:0] l, input logic [15:0] r);
      logic [63:0] b;
      logic [15:0] v;
      logic        sb;
      int          k;
      b = '0;
      for (int n = 0; n < 64; n++) begin
         k = n % 32;
         sb = 1'b0;
         if (k >= 1 && k <= 16) begin
            v = ((n < 32) ? l : r) >> (16 - k);
            sb = v[0];
         end
         b = {sb, b[63:1]};
      end
      return b;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      sample_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      cyc = 0;
   endtask

   task automatic send(input logic [15:0] l, input logic [15:0] r);
      sample_l = l;
      sample_r = r;
      sample_valid = 1'b1;
      tick();
      sample_valid = 1'b0;
   endtask

   task automatic wait_frame(output int ovr);
      ovr = 0;
      for (int n = 0; n < 2000; n++) begin
         tick();
         if (overrun) ovr++;
         if (frame_start) break;
      end
      if (!frame_start) begin
         tests++;
         fails++;
         $display("FAIL wait_frame: frame_start=%b at cyc %0d, required 1", frame_start, cyc);
      end
   endtask

   task automatic capture(output logic [63:0] d, output logic [63:0] lr);
      logic prev;
      d = '0;
      lr = '0;
      d = {i2s_sdata, d[63:1]};
      lr = {i2s_lrclk, lr[63:1]};
      for (int b = 1; b < 64; b++) begin
         int n;
         n = 0;
         do begin
            prev = i2s_bclk;
            tick();
            n++;
         end while (!(prev && !i2s_bclk) && n < 100);
         d = {i2s_sdata, d[63:1]};
         lr = {i2s_lrclk, lr[63:1]};
      end
   endtask

   task automatic check_startup(input string tag);
      int bad;
      repeat (7) tick();
      tests++;
      if (i2s_bclk !== 1'b0) begin
         fails++;
         $display("FAIL %s bclk_c7: got %b want 0", tag, i2s_bclk);
      end
      tick();
      tests++;
      if (i2s_bclk !== 1'b1) begin
         fails++;
         $display("FAIL %s bclk_c8: got %b want 1", tag, i2s_bclk);
      end
      repeat (7) tick();
      tests++;
      if ({i2s_bclk, frame_start} !== 2'b10) begin
         fails++;
         $display("FAIL %s c15 bclk/fs: got %b want 10", tag, {i2s_bclk, frame_start});
      end
      tick();
      tests++;
      if ({i2s_bclk, frame_start, underrun, overrun, i2s_lrclk} !== 5'b01100) begin
         fails++;
         $display("FAIL %s c16 bclk/fs/ur/or/lr: got %b want 01100", tag,
                  {i2s_bclk, frame_start, underrun, overrun, i2s_lrclk});
      end
      bad = 0;
      repeat (1023) begin
         tick();
         if (i2s_sdata !== 1'b0 || frame_start !== 1'b0) bad++;
      end
      tests++;
      if (bad != 0) begin
         fails++;
         $display("FAIL %s quiet_frame: got %0d bad cycles want 0", tag, bad);
      end
      tick();
      tests++;
      if ({frame_start, underrun} !== 2'b11) begin
         fails++;
         $display("FAIL %s c1040 fs/ur: got %b want 11", tag, {frame_start, underrun});
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      tests++;
      if ({i2s_bclk, i2s_lrclk, i2s_sdata, frame_start, underrun, overrun} !== 6'b0) begin
         fails++;
         $display("FAIL reset_outputs: got %b want 000000",
                  {i2s_bclk, i2s_lrclk, i2s_sdata, frame_start, underrun, overrun});
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      cyc = 0;
      check_startup("por");
   endtask

   task automatic test_pattern_and_repeat();
      logic [63:0] d, lr;
      int ov;
      do_reset();
      repeat (4) tick();
      send(16'h8001, 16'h7FFE);
      wait_frame(ov);
      tests++;
      if (cyc != 16 || underrun !== 1'b0) begin
         fails++;
         $display("FAIL pattern_fs: got cyc %0d ur %b want cyc 16 ur 0", cyc, underrun);
      end
      capture(d, lr);
      tests++;
      if (d !== PAT_D) begin
         fails++;
         $display("FAIL pattern_sdata: got %h want %h", d, PAT_D);
      end
      tests++;
      if (lr !== PAT_LR) begin
         fails++;
         $display("FAIL pattern_lrclk: got %h want %h", lr, PAT_LR);
      end
      wait_frame(ov);
      tests++;
      if (cyc != 1040 || underrun !== 1'b1) begin
         fails++;
         $display("FAIL repeat_fs: got cyc %0d ur %b want cyc 1040 ur 1", cyc, underrun);
      end
      capture(d, lr);
      tests++;
      if (d !== PAT_D) begin
         fails++;
         $display("FAIL repeat_sdata: got %h want %h", d, PAT_D);
      end
   endtask

   task automatic test_overrun();
      logic [63:0] d, lr;
      int ov;
      do_reset();
      repeat (4) tick();
      send(16'h1234, 16'h5678);
      wait_frame(ov);
      repeat (100) tick();
      send(16'h0F0F, 16'hC001);
      tests++;
      if (overrun !== 1'b0) begin
         fails++;
         $display("FAIL overrun_first: got %b want 0", overrun);
      end
      repeat (50) tick();
      send(16'hA5C3, 16'h3C5A);
      tests++;
      if (overrun !== 1'b1) begin
         fails++;
         $display("FAIL overrun_second: got %b want 1", overrun);
      end
      wait_frame(ov);
      tests++;
      if (ov != 0 || underrun !== 1'b0) begin
         fails++;
         $display("FAIL overrun_after: got extra %0d ur %b want 0 0", ov, underrun);
      end
      capture(d, lr);
      tests++;
      if (d !== exp_frame(16'hA5C3, 16'h3C5A)) begin
         fails++;
         $display("FAIL overrun_data: got %h want %h", d, exp_frame(16'hA5C3, 16'h3C5A));
      end
`ifdef OPL3_I2S_STATS_EN
      tests++;
      if (overrun_cnt !== 16'd1 || underrun_cnt !== 16'd0) begin
         fails++;
         $display("FAIL stats_cnt: got or %0d ur %0d want 1 0", overrun_cnt, underrun_cnt);
      end
`endif
   endtask

   task automatic test_collision();
      logic [63:0] d, lr;
      int ov;
      do_reset();
      repeat (4) tick();
      send(16'h4001, 16'h8002);
      wait_frame(ov);
      while (cyc < 1039) tick();
      send(16'h6DB7, 16'h9249);
      tests++;
      if ({frame_start, underrun, overrun} !== 3'b110) begin
         fails++;
         $display("FAIL collide_fs/ur/or: got %b want 110", {frame_start, underrun, overrun});
      end
      capture(d, lr);
      tests++;
      if (d !== exp_frame(16'h4001, 16'h8002)) begin
         fails++;
         $display("FAIL collide_old: got %h want %h", d, exp_frame(16'h4001, 16'h8002));
      end
      wait_frame(ov);
      tests++;
      if (cyc != 2064 || underrun !== 1'b0) begin
         fails++;
         $display("FAIL collide_next_fs: got cyc %0d ur %b want 2064 0", cyc, underrun);
      end
      capture(d, lr);
      tests++;
      if (d !== exp_frame(16'h6DB7, 16'h9249)) begin
         fails++;
         $display("FAIL collide_new: got %h want %h", d, exp_frame(16'h6DB7, 16'h9249));
      end
   endtask

   task automatic test_mid_reset();
      do_reset();
      repeat (4) tick();
      send(16'h8001, 16'h7FFE);
      while (cyc < 666) tick();
      tests++;
      if ({i2s_bclk, i2s_lrclk, i2s_sdata} !== 3'b111) begin
         fails++;
         $display("FAIL mid_bit40: got %b want 111", {i2s_bclk, i2s_lrclk, i2s_sdata});
      end
      #2;
      reset = 1'b1;
      #1;
      tests++;
      if ({i2s_bclk, i2s_lrclk, i2s_sdata, frame_start, underrun, overrun} !== 6'b0) begin
         fails++;
         $display("FAIL mid_reset_outputs: got %b want 000000",
                  {i2s_bclk, i2s_lrclk, i2s_sdata, frame_start, underrun, overrun});
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      cyc = 0;
      check_startup("mid");
   endtask

   initial begin
      test_reset();
      test_pattern_and_repeat();
      test_overrun();
      test_collision();
      test_mid_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
